press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_classifier_pkg.sv | 20 ++
 rtl/press_classifier.sv | 98 +++++++++
 tb/tb_press_classifier.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/press_classifier_pkg.sv
// Shared definitions for the press classifier: FSM state encoding
// and default timing/counter limits used by the top-level parameters.
package press_classifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } press_state_e;

    // 1 s hold at a 25 MHz system clock
    localparam int unsigned LONG_LIMIT_DEF = 25000000;
    localparam int unsigned COUNT_MAX_DEF  = 9;

    // Timer width able to hold LONG_LIMIT-1, never narrower than 1 bit
    function automatic int unsigned timer_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies a debounced switch press as short or long.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_switch  debounced switch level, 1 = pressed
//   o_short   one-cycle pulse when a short press completes (on release)
//   o_long    one-cycle pulse when a press has been held LONG_LIMIT cycles
//   o_count   short-press counter 0..COUNT_MAX, cleared by a long press
//   o_toggle  level inverted on every short press
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned LONG_LIMIT = LONG_LIMIT_DEF,
    parameter int unsigned COUNT_MAX  = COUNT_MAX_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_switch,
    output logic       o_short,
    output logic       o_long,
    output logic [3:0] o_count,
    output logic       o_toggle
);

    localparam int unsigned TW = timer_width(LONG_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LONG_LIMIT - 1);
    localparam logic [3:0]    COUNT_TOP  = 4'(COUNT_MAX);

    press_state_e  state_q;
    logic [TW-1:0] timer_q;
    logic          r_switch_q;
    logic          short_q;
    logic          long_q;
    logic [3:0]    count_q;
    logic          toggle_q;

    logic          press;
    logic [3:0]    count_d;

    // Rising edge of the switch; r_switch_q resets high so a switch
    // held through reset must be released before it can register.
    assign press = i_switch & ~r_switch_q;

    assign count_d = (count_q >= COUNT_TOP) ? 4'd0 : count_q + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            r_switch_q <= 1'b1;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= 4'd0;
            toggle_q   <= 1'b0;
        end else begin
            r_switch_q <= i_switch;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        state_q <= ST_PRESSED;
                        timer_q <= '0;
                    end
                end
                ST_PRESSED: begin
                    // Release wins over reaching the threshold
                    if (!i_switch) begin
                        state_q  <= ST_IDLE;
                        short_q  <= 1'b1;
                        count_q  <= count_d;
                        toggle_q <= ~toggle_q;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= ST_LONG;
                        long_q  <= 1'b1;
                        count_q <= 4'd0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!i_switch) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_count  = count_q;
    assign o_toggle = toggle_q;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier with LONG_LIMIT=8, COUNT_MAX=9.
// Table of per-cycle vectors plus hand-written reset sequences.
module tb_press_classifier;

    localparam int L = 8;

    typedef struct {
        logic       sw;
        logic       s;
        logic       l;
        logic [3:0] c;
        logic       t;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       o_short;
    logic       o_long;
    logic [3:0] o_count;
    logic       o_toggle;

    int checks;
    int errors;
    int exp_c;
    logic exp_t;
    vec_t vecs[$];

    press_classifier #(
        .LONG_LIMIT(L),
        .COUNT_MAX (9)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_switch(sw),
        .o_short (o_short),
        .o_long  (o_long),
        .o_count (o_count),
        .o_toggle(o_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int idx, input logic s,
                           input logic l, input logic [3:0] c, input logic t);
        chk({name, ".short"}, idx, {3'b0, o_short}, {3'b0, s});
        chk({name, ".long"}, idx, {3'b0, o_long}, {3'b0, l});
        chk({name, ".count"}, idx, o_count, c);
        chk({name, ".toggle"}, idx, {3'b0, o_toggle}, {3'b0, t});
        chk({name, ".excl"}, idx, {3'b0, o_short & o_long}, 4'd0);
    endtask

    task automatic step(input logic v);
        sw = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic s, input logic l);
        vec_t r;
        r.sw = v;
        r.s  = s;
        r.l  = l;
        r.c  = 4'(exp_c);
        r.t  = exp_t;
        vecs.push_back(r);
    endtask

    // n cycles high then release; short if n <= L, long otherwise
    task automatic add_press(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == L) begin
                exp_c = 0;
                add(1'b1, 1'b0, 1'b1);
            end else begin
                add(1'b1, 1'b0, 1'b0);
            end
        end
        if (n <= L) begin
            exp_c = (exp_c == 9) ? 0 : exp_c + 1;
            exp_t = ~exp_t;
            add(1'b0, 1'b1, 1'b0);
        end else begin
            add(1'b0, 1'b0, 1'b0);
        end
        add(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_c  = 0;
        exp_t  = 1'b0;
        sw     = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all("reset", 0, 1'b0, 1'b0, 4'd0, 1'b0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        add(1'b0, 1'b0, 1'b0);
        add_press(3);
        add_press(L);
        add_press(20);
        for (int k = 0; k < 10; k++) add_press(2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sw);
            chk_all("vec", i, vecs[i].s, vecs[i].l, vecs[i].c, vecs[i].t);
        end
        chk("end_count", 0, o_count, 4'd0);
        chk("end_toggle", 0, {3'b0, o_toggle}, 4'd0);

        // Reset in the middle of a press
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        chk_all("pre_abort", 0, 1'b1, 1'b0, 4'd1, 1'b1);
        step(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);
        #3;
        sw    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("abort_now", 0, 1'b0, 1'b0, 4'd0, 1'b0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            chk_all("abort_after", i, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // Switch held through reset release is ignored
        sw    = 1'b1;
        #2;
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            chk_all("held", i, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        step(1'b0);
        chk_all("held_rel", 0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        chk_all("second", 0, 1'b1, 1'b0, 4'd1, 1'b1);
        step(1'b0);
        chk_all("second_idle", 0, 1'b0, 1'b0, 4'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
